// File: rtl/lcd_ctrl_pkg.sv
// Shared types and elaboration helpers for the 8080 panel stream controller.
// Used by lcd_word_fifo and lcd_8080_stream_ctrl.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RES_LOW  = 4'd1,
    ST_RES_WAIT = 4'd2,
    ST_CS_SETUP = 4'd3,
    ST_WR_LO    = 4'd4,
    ST_WR_HI    = 4'd5,
    ST_CS_OPEN  = 4'd6,
    ST_CS_HOLD  = 4'd7,
    ST_RD_LO    = 4'd8,
    ST_RD_HI    = 4'd9
  } lcd_state_e;

  // Widest supported panel bus; narrower buses zero-extend into the entry.
  localparam int unsigned LCD_MAX_W = 18;

  typedef struct packed {
    logic                 last;
    logic                 dcx;
    logic [LCD_MAX_W-1:0] data;
  } lcd_entry_t;

  function automatic int unsigned entry_width(input int unsigned data_w);
    return data_w + 32'd2;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // The shared timer holds at most max_cnt-1.
  function automatic int unsigned cnt_width(input int unsigned max_cnt);
    return (max_cnt < 32'd3) ? 32'd1 : $clog2(max_cnt);
  endfunction

endpackage

// File: rtl/lcd_word_fifo.sv
// Single-clock word FIFO with occupancy output; pointers and level reset
// asynchronously, storage is left unreset.
module lcd_word_fifo
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == LVL_W'(0));
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // storage write
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LVL_W'(0);
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_8080_stream_ctrl.sv
// MIPI-DBI type-B (8080) write streamer with RESX sequencer and CSX bursts.
// Optional panel read path enabled by defining LCD_CTRL_READ_EN.
module lcd_8080_stream_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CS_SETUP   = 1,
  parameter int unsigned WR_LOW     = 2,
  parameter int unsigned WR_HIGH    = 2,
  parameter int unsigned CS_HOLD    = 1,
  parameter int unsigned RES_PULSE  = 10,
  parameter int unsigned RES_WAIT   = 120
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_dcx,
  input  logic                          in_last,
  input  logic                          hw_reset_req,
  input  logic                          lcd_on_ctrl,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          rd_req,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic [DATA_W-1:0]             lcd_data_out,
  output logic                          lcd_data_oe,
  input  logic [DATA_W-1:0]             lcd_data_in,
  output logic                          lcd_csx,
  output logic                          lcd_dcx,
  output logic                          lcd_wrx,
  output logic                          lcd_rdx,
  output logic                          lcd_resx,
  output logic                          lcd_on
);

  localparam int unsigned ENT_W   = entry_width(DATA_W);
  localparam int unsigned CNT_MAX = max2(max2(max2(CS_SETUP, WR_LOW), max2(WR_HIGH, CS_HOLD)),
                                         max2(RES_PULSE, RES_WAIT));
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);

  localparam logic [CNT_W-1:0] L_CS_SETUP  = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] L_WR_LOW    = CNT_W'(WR_LOW - 1);
  localparam logic [CNT_W-1:0] L_WR_HIGH   = CNT_W'(WR_HIGH - 1);
  localparam logic [CNT_W-1:0] L_CS_HOLD   = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] L_RES_PULSE = CNT_W'(RES_PULSE - 1);
  localparam logic [CNT_W-1:0] L_RES_WAIT  = CNT_W'(RES_WAIT - 1);

  lcd_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pend_q;
  logic              rd_flag_q;
  logic              last_q;
  logic              csx_q, wrx_q, rdx_q, resx_q, dcx_q, oe_q, on_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              push_s, pop_s, full_s, empty_s, cnt_done_s;
  logic [ENT_W-1:0]  fifo_rdata_s;
  lcd_entry_t        fifo_ent_s;
  logic              unused_s;

  assign push_s     = in_valid & ~full_s;
  assign cnt_done_s = (cnt_q == CNT_W'(0));
  assign fifo_ent_s = {fifo_rdata_s[DATA_W+1], fifo_rdata_s[DATA_W],
                       LCD_MAX_W'(fifo_rdata_s[DATA_W-1:0])};

  lcd_word_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_s),
    .wdata_i ({in_last, in_dcx, in_data}),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .level_o (fifo_level)
  );

  // word fetch points: end of setup, end of a non-final high phase, or an open burst
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      ST_CS_SETUP: begin
        if (cnt_done_s && !rd_flag_q && !empty_s) pop_s = 1'b1;
        else                                      pop_s = 1'b0;
      end
      ST_WR_HI: begin
        if (cnt_done_s && !last_q && !pend_q && !empty_s) pop_s = 1'b1;
        else                                              pop_s = 1'b0;
      end
      ST_CS_OPEN: begin
        if (!pend_q && !empty_s) pop_s = 1'b1;
        else                     pop_s = 1'b0;
      end
      default: pop_s = 1'b0;
    endcase
  end

  // sequencer: state, shared timer and registered panel strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_W'(0);
      pend_q     <= 1'b0;
      rd_flag_q  <= 1'b0;
      last_q     <= 1'b0;
      csx_q      <= 1'b1;
      wrx_q      <= 1'b1;
      rdx_q      <= 1'b1;
      resx_q     <= 1'b1;
      dcx_q      <= 1'b0;
      oe_q       <= 1'b1;
      on_q       <= 1'b0;
      data_q     <= DATA_W'(0);
      rd_valid_q <= 1'b0;
      rd_data_q  <= DATA_W'(0);
    end else begin
      on_q       <= lcd_on_ctrl;
      rd_valid_q <= 1'b0;
      if (hw_reset_req) pend_q <= 1'b1;
      if (!cnt_done_s) cnt_q <= cnt_q - CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (hw_reset_req || pend_q) begin
            pend_q  <= 1'b0;
            resx_q  <= 1'b0;
            cnt_q   <= L_RES_PULSE;
            state_q <= ST_RES_LOW;
          end else if (!empty_s) begin
            csx_q   <= 1'b0;
            cnt_q   <= L_CS_SETUP;
            state_q <= ST_CS_SETUP;
          end
`ifdef LCD_CTRL_READ_EN
          else if (rd_req) begin
            rd_flag_q <= 1'b1;
            csx_q     <= 1'b0;
            cnt_q     <= L_CS_SETUP;
            state_q   <= ST_CS_SETUP;
          end
`endif
        end
        ST_RES_LOW: begin
          if (cnt_done_s) begin
            resx_q  <= 1'b1;
            cnt_q   <= L_RES_WAIT;
            state_q <= ST_RES_WAIT;
          end
        end
        ST_RES_WAIT: begin
          if (cnt_done_s) state_q <= ST_IDLE;
        end
        ST_CS_SETUP: begin
`ifdef LCD_CTRL_READ_EN
          if (cnt_done_s && rd_flag_q) begin
            rdx_q   <= 1'b0;
            oe_q    <= 1'b0;
            dcx_q   <= 1'b1;
            cnt_q   <= L_WR_LOW;
            state_q <= ST_RD_LO;
          end
`endif
        end
        ST_WR_LO: begin
          if (cnt_done_s) begin
            wrx_q   <= 1'b1;
            cnt_q   <= L_WR_HIGH;
            state_q <= ST_WR_HI;
          end
        end
        ST_WR_HI: begin
          // a pending hardware reset closes the burst even if words are queued
          if (cnt_done_s) begin
            if (last_q || pend_q) begin
              cnt_q   <= L_CS_HOLD;
              state_q <= ST_CS_HOLD;
            end else if (empty_s) begin
              state_q <= ST_CS_OPEN;
            end
          end
        end
        ST_CS_OPEN: begin
          if (pend_q) begin
            cnt_q   <= L_CS_HOLD;
            state_q <= ST_CS_HOLD;
          end
        end
        ST_CS_HOLD: begin
          if (cnt_done_s) begin
            csx_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
`ifdef LCD_CTRL_READ_EN
        ST_RD_LO: begin
          if (cnt_done_s) begin
            rd_data_q  <= lcd_data_in;
            rd_valid_q <= 1'b1;
            rdx_q      <= 1'b1;
            cnt_q      <= L_WR_HIGH;
            state_q    <= ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          if (cnt_done_s) begin
            oe_q      <= 1'b1;
            rd_flag_q <= 1'b0;
            cnt_q     <= L_CS_HOLD;
            state_q   <= ST_CS_HOLD;
          end
        end
`endif
        default: begin
          csx_q   <= 1'b1;
          wrx_q   <= 1'b1;
          rdx_q   <= 1'b1;
          resx_q  <= 1'b1;
          oe_q    <= 1'b1;
          cnt_q   <= CNT_W'(0);
          state_q <= ST_IDLE;
        end
      endcase
      if (pop_s) begin
        data_q  <= fifo_ent_s.data[DATA_W-1:0];
        dcx_q   <= fifo_ent_s.dcx;
        last_q  <= fifo_ent_s.last;
        wrx_q   <= 1'b0;
        cnt_q   <= L_WR_LOW;
        state_q <= ST_WR_LO;
      end
    end
  end

`ifdef LCD_CTRL_READ_EN
  assign unused_s = ^fifo_ent_s.data;
`else
  assign unused_s = ^{fifo_ent_s.data, rd_req, lcd_data_in};
`endif

  assign in_ready     = ~full_s;
  assign busy         = (state_q != ST_IDLE) || !empty_s;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign lcd_data_out = data_q;
  assign lcd_data_oe  = oe_q;
  assign lcd_csx      = csx_q;
  assign lcd_dcx      = dcx_q;
  assign lcd_wrx      = wrx_q;
  assign lcd_rdx      = rdx_q;
  assign lcd_resx     = resx_q;
  assign lcd_on       = on_q;

endmodule

// File: tb/tb_lcd_8080_stream_ctrl.sv
// Self-checking bench for lcd_8080_stream_ctrl (default parameters); the read
// test adapts to whether LCD_CTRL_READ_EN is defined.
module tb_lcd_8080_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_dcx, in_last;
  logic [15:0] in_data;
  logic        hw_reset_req, lcd_on_ctrl, busy;
  logic [4:0]  fifo_level;
  logic        rd_req, rd_valid;
  logic [15:0] rd_data, lcd_data_out, lcd_data_in;
  logic        lcd_data_oe, lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx, lcd_resx, lcd_on;

  always #5 clk = ~clk;

  lcd_8080_stream_ctrl dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dcx(in_dcx), .in_last(in_last),
    .hw_reset_req(hw_reset_req), .lcd_on_ctrl(lcd_on_ctrl), .busy(busy),
    .fifo_level(fifo_level), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe), .lcd_data_in(lcd_data_in),
    .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx), .lcd_wrx(lcd_wrx), .lcd_rdx(lcd_rdx),
    .lcd_resx(lcd_resx), .lcd_on(lcd_on)
  );

  typedef struct { logic [15:0] data; logic dcx; } exp_t;
  typedef struct { int off; logic csx; logic wrx; logic dcx; } vec_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        tv[7];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          fall_cyc[$];
  int          ncsx_rise, res_low, rdx_low, rd_strobe_ok, rdv_cnt, oe_low;
  int          resx_rise_cyc, csx_fall_cyc;
  logic [15:0] rd_cap;
  logic        prev_wrx = 1'b1, prev_csx = 1'b1, prev_resx = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // bus monitor: every WRX fall is scored against the expected-word queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_wrx && !lcd_wrx) begin
        fall_cyc.push_back(cyc);
        check("csx_low_at_wr", 32'(lcd_csx), 32'd0);
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("word_data", 32'(lcd_data_out), 32'(mon_e.data));
          check("word_dcx", 32'(lcd_dcx), 32'(mon_e.dcx));
        end
      end
      if (!prev_csx && lcd_csx) ncsx_rise++;
      if (prev_csx && !lcd_csx) csx_fall_cyc = cyc;
      if (!lcd_resx) res_low++;
      if (!prev_resx && lcd_resx) resx_rise_cyc = cyc;
      if (!lcd_rdx) rdx_low++;
      if (!lcd_rdx && !lcd_data_oe && lcd_dcx && !lcd_csx) rd_strobe_ok++;
      if (!lcd_data_oe) oe_low++;
      if (rd_valid) begin
        rdv_cnt++;
        rd_cap = rd_data;
      end
    end
    prev_wrx  = lcd_wrx;
    prev_csx  = lcd_csx;
    prev_resx = lcd_resx;
  end

  task automatic send(input logic [15:0] d, input logic x, input logic l);
    int w;
    w = 0;
    in_data = d; in_dcx = x; in_last = l; in_valid = 1'b1;
    while (!in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else           sb.push_back('{data: d, dcx: x});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int w;
    w = 0;
    while (busy && w < bound) begin
      @(negedge clk);
      w++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_wrx_low(input int bound);
    int w;
    w = 0;
    while (lcd_wrx && w < bound) begin
      @(negedge clk);
      w++;
    end
    check("wrx_low_timeout", 32'(lcd_wrx), 32'd0);
  endtask

  task automatic pulse_hw_reset();
    hw_reset_req = 1'b1;
    @(negedge clk);
    hw_reset_req = 1'b0;
  endtask

  task automatic check_reset(input string pre);
    check({pre, "_strobes"},
          32'({lcd_csx, lcd_wrx, lcd_rdx, lcd_resx, lcd_dcx, lcd_on,
               lcd_data_oe, in_ready, rd_valid, busy}), 32'b1111001100);
    check({pre, "_data_out"}, 32'(lcd_data_out), 32'd0);
    check({pre, "_rd_data"}, 32'(rd_data), 32'd0);
    check({pre, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single-command timing, offsets from the first CSX-low cycle
    tv[0] = '{0, 1'b0, 1'b1, 1'b0};
    tv[1] = '{1, 1'b0, 1'b0, 1'b0};
    tv[2] = '{2, 1'b0, 1'b0, 1'b0};
    tv[3] = '{3, 1'b0, 1'b1, 1'b0};
    tv[4] = '{4, 1'b0, 1'b1, 1'b0};
    tv[5] = '{5, 1'b0, 1'b1, 1'b0};
    tv[6] = '{6, 1'b1, 1'b1, 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_dcx = 1'b0; in_last = 1'b0;
    hw_reset_req = 1'b0; lcd_on_ctrl = 1'b0; rd_req = 1'b0; lcd_data_in = 16'h9341;
    ncsx_rise = 0; res_low = 0; rdx_low = 0; rd_strobe_ok = 0; rdv_cnt = 0; oe_low = 0;
    resx_rise_cyc = 0; csx_fall_cyc = 0; rd_cap = 16'h0;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    @(negedge clk);

    lcd_on_ctrl = 1'b1;
    #1 check("lcd_on_before_edge", 32'(lcd_on), 32'd0);
    @(negedge clk);
    check("lcd_on_after_edge", 32'(lcd_on), 32'd1);

    // single command 0x002C
    send(16'h002C, 1'b0, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t1_csx_T+%0d", tv[i].off), 32'(lcd_csx), 32'(tv[i].csx));
      check($sformatf("t1_wrx_T+%0d", tv[i].off), 32'(lcd_wrx), 32'(tv[i].wrx));
      check($sformatf("t1_dcx_T+%0d", tv[i].off), 32'(lcd_dcx), 32'(tv[i].dcx));
      if (i < 6) @(negedge clk);
    end
    wait_idle(50);

    // burst: command + 4 data words, back to back
    fall_cyc.delete();
    ncsx_rise = 0;
    send(16'h002C, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(16'h1100 + 16'(i), 1'b1, (i == 3));
    wait_idle(200);
    check("t2_wr_pulses", 32'(fall_cyc.size()), 32'd5);
    for (int i = 0; i + 1 < fall_cyc.size(); i++)
      check($sformatf("t2_spacing_%0d", i), 32'(fall_cyc[i+1] - fall_cyc[i]), 32'd4);
    check("t2_csx_rises", 32'(ncsx_rise), 32'd1);

    // fill the FIFO while the panel is held in hardware reset
    fall_cyc.delete();
    pulse_hw_reset();
    check("t3_resx_low", 32'(lcd_resx), 32'd0);
    for (int i = 0; i < 16; i++) send(16'h0100 + 16'(i), i[0], (i == 15));
    check("t3_level_full", 32'(fifo_level), 32'd16);
    check("t3_in_ready_full", 32'(in_ready), 32'd0);
    in_data = 16'hDEAD; in_dcx = 1'b1; in_last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t3_level_after_17th", 32'(fifo_level), 32'd16);
    wait_idle(600);
    check("t3_wr_pulses", 32'(fall_cyc.size()), 32'd16);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // hardware reset requested during WR_LO of a burst
    fall_cyc.delete();
    ncsx_rise = 0;
    res_low = 0;
    send(16'h002A, 1'b0, 1'b0);
    send(16'h0055, 1'b1, 1'b0);
    send(16'h00AA, 1'b1, 1'b1);
    wait_wrx_low(20);
    pulse_hw_reset();
    wait_idle(600);
    check("t4_wr_pulses", 32'(fall_cyc.size()), 32'd3);
    check("t4_csx_rises", 32'(ncsx_rise), 32'd2);
    check("t4_resx_low_cycles", 32'(res_low), 32'd10);
    check("t4_wait_to_csx", 32'(csx_fall_cyc - resx_rise_cyc), 32'd121);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);

    // asynchronous reset in the middle of a write
    send(16'h3C3C, 1'b1, 1'b0);
    send(16'h4D4D, 1'b1, 1'b1);
    wait_wrx_low(20);
    #2 reset_n = 1'b0;
    #1 check_reset("async");
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // panel read
    rdx_low = 0; rd_strobe_ok = 0; rdv_cnt = 0; oe_low = 0;
    lcd_data_in = 16'h9341;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
`ifdef LCD_CTRL_READ_EN
    wait_idle(50);
    check("rd_rdx_low_cycles", 32'(rdx_low), 32'd2);
    check("rd_oe_dcx_during_rdx", 32'(rd_strobe_ok), 32'd2);
    check("rd_valid_pulses", 32'(rdv_cnt), 32'd1);
    check("rd_data", 32'(rd_cap), 32'h9341);
`else
    repeat (20) @(negedge clk);
    check("rd_valid_pulses", 32'(rdv_cnt), 32'd0);
    check("rd_rdx_low_cycles", 32'(rdx_low), 32'd0);
    check("rd_oe_low_cycles", 32'(oe_low), 32'd0);
    check("rd_busy", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_8080_stream_ctrl.md
Name: lcd_8080_stream_ctrl

Overview:
- Parametrised successor to the current fixed 16-bit LCD controller; drives an MIPI-DBI type-B (8080) parallel panel: DATA, DCX, CSX, WRX, RDX, RESX, LCD_ON.
- Accepts a valid/ready stream of command/data words, buffers them in an internal FIFO and emits timed write cycles with programmable bus width and timing.
- Adds a hardware reset sequencer and CSX burst framing; sits between the Avalon-MM slave/DMA front end and the panel pins.

Parameters:
- DATA_W, 16, panel bus width (8, 9, 16 or 18).
- FIFO_DEPTH, 16, word FIFO entries; power of two, ≥2.
- CS_SETUP, 1, cycles CSX low before the first WRX fall (≥1).
- WR_LOW, 2, cycles WRX low per word (≥1).
- WR_HIGH, 2, cycles WRX high per word (≥1).
- CS_HOLD, 1, cycles CSX stays low after the last WRX high phase (≥1).
- RES_PULSE, 10, cycles RESX low during a hardware reset.
- RES_WAIT, 120, cycles after RESX rises before any access.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  stream word valid.
- in_ready  out  1  FIFO not full.
- in_data  in  DATA_W  command or data word.
- in_dcx  in  1  0 = command, 1 = data.
- in_last  in  1  close the CSX burst after this word.
- hw_reset_req  in  1  single-cycle pulse; run the RESX sequence.
- lcd_on_ctrl  in  1  register level mirrored to lcd_on.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- rd_req  in  1  read one word (active only with macro).
- rd_valid  out  1  one-cycle read-result strobe.
- rd_data  out  DATA_W  sampled panel data.
- lcd_data_out  out  DATA_W  bus drive value.
- lcd_data_oe  out  1  bus output enable.
- lcd_data_in  in  DATA_W  bus sample value.
- lcd_csx, lcd_dcx, lcd_wrx, lcd_rdx, lcd_resx, lcd_on  out  1 each  panel strobes.

Behaviour:
- Reset values: csx=1, wrx=1, rdx=1, resx=1, dcx=0, lcd_on=0, data_out=0, oe=1, in_ready=1, rd_valid=0, rd_data=0, FIFO empty. Reset mid-transaction aborts it immediately with these values; FIFO contents are discarded.
- lcd_on is a registered copy of lcd_on_ctrl (1-cycle latency).
- FIFO: push when in_valid & in_ready; each entry holds {last, dcx, data}. in_ready=0 when full. Simultaneous push and pop at full is not accepted (in_ready already 0); at empty, a push becomes visible to the FSM the next cycle.
- FSM states: IDLE, RES_LOW, RES_WAIT, CS_SETUP, WR_LO, WR_HI, CS_OPEN, CS_HOLD, RD_LO, RD_HI. One shared down-counter loads on every state entry.
- IDLE: a pending hw_reset goes to RES_LOW (priority). Else FIFO non-empty goes to CS_SETUP. Else rd_req (with macro) goes to CS_SETUP, flagged as a read.
- RES_LOW: resx=0 for RES_PULSE cycles, then RES_WAIT (resx=1) for RES_WAIT cycles, then IDLE.
- hw_reset_req pulses outside IDLE are latched in a pending flag and serviced after CS_HOLD completes. Further pulses while pending are merged.
- CS_SETUP: csx=0 for CS_SETUP cycles. Then pop a word into the output register and go to WR_LO.
- WR_LO: wrx=0; data and dcx stable; lasts WR_LOW cycles. WR_HI: wrx=1; data held; lasts WR_HIGH cycles.
- After WR_HI:
  - If last=1, go to CS_HOLD.
  - Else if FIFO non-empty, pop and go straight to WR_LO (no CSX gap; one word every WR_LOW+WR_HIGH cycles).
  - Else go to CS_OPEN (csx stays low) and wait for the next word, then WR_LO.
- CS_OPEN: a pending hw_reset forces CS_HOLD.
- CS_HOLD: csx=0 for CS_HOLD cycles, then csx=1 and IDLE. CSX is high for at least 1 cycle between bursts.
- Width: in_data is used as-is. When DATA_W=8, software supplies 16-bit pixels as two words.

Optional Feature:
- Macro: LCD_CTRL_READ_EN.
- With the macro, a read from IDLE runs CS_SETUP, then RD_LO (rdx=0, oe=0, dcx=1) for WR_LOW cycles, then RD_HI for WR_HIGH cycles.
  - lcd_data_in is sampled on the last RD_LO cycle.
  - rd_valid pulses on the first RD_HI cycle; CS_HOLD follows.
  - rd_req while not IDLE is ignored.
- Without the macro: rd_req is ignored, rdx=1 and oe=1 constantly, rd_valid=0, rd_data=0.

Decomposition:
- Package lcd_ctrl_pkg: state enum, entry struct {last, dcx, data} (width parameterised through a localparam function), counter width helper.
- Sub-module lcd_word_fifo (synchronous FIFO with level output, single clock); the FSM and timers live in the top module.

Test Plan:
- Single command 0x002C, last=1, defaults → csx falls at T; wrx low T+1..T+2, high T+3..T+4; csx=0 at T+5, high at T+6; dcx=0 throughout.
- Burst cmd 0x2C + 4 data words (last on the 4th) pushed back-to-back → csx low continuously; 5 WRX pulses 4 cycles apart; dcx=0 then 1; single CSX rise.
- Fill 16 words with the panel stalled behind hw_reset → in_ready=0 at level 16; a 17th push is refused; all 16 words later emitted in order.
- hw_reset_req during WR_LO of a non-last burst → current word completes, CS_HOLD, resx low 10 cycles, wait 120, then remaining FIFO words emitted in a new burst.
- Async reset_n low mid-WR_LO → all outputs at reset values in the same cycle; fifo_level=0.
- LCD_CTRL_READ_EN build, rd_req with lcd_data_in=0x9341 → rdx low 2 cycles, oe=0, rd_valid one cycle with rd_data=0x9341; non-macro build leaves rd_valid=0.
